// File: rtl/dmem_pkg.sv
// dmem_pkg: shared modes, arbiter states and alignment helper for the data-memory arbiter
package dmem_pkg;
  localparam logic [1:0] MODE_W = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_B = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_CORE, ST_DMA, ST_LOCK} state_t;
  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic        sext;
  } acc_t;
  function automatic logic align_ok(input logic [1:0] mode, input logic [8:0] addr);
    return mode == MODE_B ? 1'b1 : mode == MODE_H ? !addr[0] : addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: flags an access as legal when aligned for its mode and inside the memory window
module dmem_align_chk
  import dmem_pkg::*;
#(
  parameter logic [6:0] BASE_WORD = 7'h40
) (
  input  logic [1:0] mode,
  input  logic [8:0] addr,
  output logic       ok
);
  assign ok = align_ok(mode, addr) && addr[8:2] >= BASE_WORD;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between core and DMA with starvation guard and DMA burst lock
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4,
  parameter logic [6:0]  BASE_WORD  = 7'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [8:0]  core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_mode,
  input  logic        core_sext,
  output logic        core_ack,
  output logic        core_err,
  output logic [31:0] core_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [8:0]  dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_mode,
  input  logic        dma_sext,
  input  logic        dma_lock,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_mode,
  output logic        mem_sext,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  starve_cnt
);
  localparam logic [2:0] MAX_S = 3'(MAX_STARVE);
  state_t     state, state_nxt;
  logic [2:0] starve, starve_nxt;
  logic       dma_win, core_win, any_win, ok;
  acc_t       core_acc, dma_acc, win;
  assign core_acc = '{we: core_we, addr: core_addr, wdata: core_wdata, mode: core_mode, sext: core_sext};
  assign dma_acc  = '{we: dma_we, addr: dma_addr, wdata: dma_wdata, mode: dma_mode, sext: dma_sext};
  // Pick the winner (lock, then starvation, then core priority), mux its fields, and compute next state; reset drops everything at once
  always_comb begin
    dma_win    = !rst && dma_req && (state == ST_LOCK || starve == MAX_S || !core_req);
    core_win   = !rst && core_req && !dma_win;
    any_win    = dma_win || core_win;
    win        = dma_win ? dma_acc : core_win ? core_acc : '0;
    state_nxt  = dma_win ? (dma_lock ? ST_LOCK : ST_DMA) : core_win ? ST_CORE : ST_IDLE;
    starve_nxt = core_win && dma_req ? (starve == MAX_S ? starve : starve + 3'd1) : 3'd0;
  end
  dmem_align_chk #(.BASE_WORD(BASE_WORD)) u_chk (
    .mode(win.mode),
    .addr(win.addr),
    .ok  (ok)
  );
  assign mem_read   = any_win && !win.we && ok;
  assign mem_write  = any_win && win.we && ok;
  assign mem_addr   = win.addr;
  assign mem_wdata  = win.wdata;
  assign mem_mode   = win.mode;
  assign mem_sext   = win.sext;
  assign core_ack   = core_win && ok;
  assign core_err   = core_win && !ok;
  assign dma_ack    = dma_win && ok;
  assign dma_err    = dma_win && !ok;
  assign core_rdata = core_win ? mem_rdata : '0;
  assign dma_rdata  = dma_win ? mem_rdata : '0;
  assign starve_cnt = starve;
  // Grant history and starvation count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/memory model
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_sext, core_ack, core_err;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic [1:0]  core_mode;
  logic        dma_req, dma_we, dma_sext, dma_lock, dma_ack, dma_err;
  logic [8:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic [1:0]  dma_mode;
  logic        mem_read, mem_write, mem_sext;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_mode;
  logic [2:0]  starve_cnt;
  int total = 0;
  int pass = 0;
  logic [31:0] env [0:127] = '{default: 32'h0};
  logic [7:0]  ref_mem [0:511];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mode(core_mode), .core_sext(core_sext), .core_ack(core_ack), .core_err(core_err),
    .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_mode(dma_mode), .dma_sext(dma_sext), .dma_lock(dma_lock), .dma_ack(dma_ack),
    .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_sext(mem_sext), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: combinational read with lane select and sign extension
  always_comb begin
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = env[mem_addr[8:2]];
    h = mem_addr[1] ? w[31:16] : w[15:0];
    b = w[8*mem_addr[1:0] +: 8];
    mem_rdata = mem_mode == 2'b01 ? (mem_sext ? {{16{h[15]}}, h} : {16'h0, h}) :
                mem_mode == 2'b10 ? (mem_sext ? {{24{b[7]}}, b} : {24'h0, b}) : w;
  end

  // data_memory stand-in: write on rising edge
  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_mode == 2'b01) env[mem_addr[8:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
      else if (mem_mode == 2'b10) env[mem_addr[8:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
      else env[mem_addr[8:2]] <= mem_wdata;
    end
  end

  function automatic logic [31:0] ref_load(int a, int mode, bit sx);
    logic [31:0] v;
    int base;
    if (mode == 2) begin
      v = {24'h0, ref_mem[a]};
      if (sx && v[7]) v[31:8] = '1;
    end else if (mode == 1) begin
      v = {16'h0, ref_mem[a+1], ref_mem[a]};
      if (sx && v[15]) v[31:16] = '1;
    end else begin
      base = a - (a % 4);
      v = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end
    return v;
  endfunction

  task automatic ref_store(int a, int mode, logic [31:0] d);
    int n;
    n = mode == 2 ? 1 : mode == 1 ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_mode = 0; core_sext = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_mode = 0; dma_sext = 0; dma_lock = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    core_req = 1; core_addr = 9'h104;
    dma_req = 1; dma_we = 1; dma_addr = 9'h108; dma_wdata = 32'h55;
    #2;
    total++; if ({core_ack, core_err, dma_ack, dma_err} !== 4'b0) $display("FAIL reset_acks got %b exp 0000", {core_ack, core_err, dma_ack, dma_err}); else pass++;
    total++; if ({mem_read, mem_write} !== 2'b0) $display("FAIL reset_mem_rw got %b exp 00", {mem_read, mem_write}); else pass++;
    total++; if ({mem_addr, mem_wdata, mem_mode, mem_sext} !== 44'h0) $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata, mem_mode, mem_sext}); else pass++;
    total++; if ({core_rdata, dma_rdata} !== 64'h0) $display("FAIL reset_rdata got %h exp 0", {core_rdata, dma_rdata}); else pass++;
    total++; if (starve_cnt !== 3'd0) $display("FAIL reset_starve got %0d exp 0", starve_cnt); else pass++;
    reset_dut();
  endtask

  task automatic test_core_alone();
    reset_dut();
    core_req = 1; core_we = 1; core_addr = 9'h104; core_wdata = 32'hCAFEFACE; core_mode = 2'b00;
    @(negedge clk);
    total++; if ({core_ack, mem_write, mem_wdata} !== {2'b11, 32'hCAFEFACE}) $display("FAIL core_store got ack/wr/wd %b %b %h exp 1 1 cafeface", core_ack, mem_write, mem_wdata); else pass++;
    next();
    core_we = 0;
    @(negedge clk);
    total++; if ({core_ack, mem_read} !== 2'b11) $display("FAIL core_load_ack got ack/rd %b %b exp 1 1", core_ack, mem_read); else pass++;
    total++; if (core_rdata !== 32'hCAFEFACE) $display("FAIL core_load_data got %h exp cafeface", core_rdata); else pass++;
    total++; if (mem_addr !== 9'h104) $display("FAIL core_load_addr got %h exp 104", mem_addr); else pass++;
    total++; if (dma_rdata !== 32'h0) $display("FAIL core_load_dma_rdata got %h exp 0", dma_rdata); else pass++;
    next();
    core_addr = 9'h107; core_mode = 2'b10; core_sext = 1;
    @(negedge clk);
    total++; if ({mem_mode, mem_sext, core_rdata} !== {2'b10, 1'b1, 32'hFFFFFFCA}) $display("FAIL core_load_byte got %b %b %h exp 10 1 ffffffca", mem_mode, mem_sext, core_rdata); else pass++;
    next();
    idle();
  endtask

  task automatic test_starvation();
    reset_dut();
    core_req = 1; core_addr = 9'h104;
    dma_req = 1; dma_addr = 9'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({core_ack, dma_ack, starve_cnt} !== {2'b10, 3'(i)}) $display("FAIL starve_core_%0d got core/dma/cnt %b %b %0d exp 1 0 %0d", i, core_ack, dma_ack, starve_cnt, i); else pass++;
      next();
    end
    @(negedge clk);
    total++; if ({core_ack, dma_ack, starve_cnt} !== {2'b01, 3'd4}) $display("FAIL starve_dma got core/dma/cnt %b %b %0d exp 0 1 4", core_ack, dma_ack, starve_cnt); else pass++;
    next();
    @(negedge clk);
    total++; if ({core_ack, dma_ack, starve_cnt} !== {2'b10, 3'd0}) $display("FAIL starve_resume got core/dma/cnt %b %b %0d exp 1 0 0", core_ack, dma_ack, starve_cnt); else pass++;
    next();
    idle();
  endtask

  task automatic test_lock();
    reset_dut();
    dma_req = 1; dma_lock = 1; dma_addr = 9'h100;
    @(negedge clk);
    total++; if (dma_ack !== 1'b1) $display("FAIL lock_grant got %b exp 1", dma_ack); else pass++;
    next();
    core_req = 1; core_addr = 9'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({dma_ack, core_ack, core_rdata} !== {2'b10, 32'h0}) $display("FAIL lock_hold_%0d got dma/core/crd %b %b %h exp 1 0 0", i, dma_ack, core_ack, core_rdata); else pass++;
      next();
    end
    dma_req = 0;
    @(negedge clk);
    total++; if ({dma_ack, core_ack} !== 2'b01) $display("FAIL lock_release got dma/core %b %b exp 0 1", dma_ack, core_ack); else pass++;
    next();
    idle();
  endtask

  task automatic test_misaligned();
    reset_dut();
    core_req = 1; core_we = 1; core_addr = 9'h105; core_mode = 2'b01; core_wdata = 32'h0000FFFF;
    @(negedge clk);
    total++; if ({core_err, core_ack, mem_write} !== 3'b100) $display("FAIL mis_h_store got err/ack/wr %b %b %b exp 1 0 0", core_err, core_ack, mem_write); else pass++;
    next();
    core_we = 0; core_addr = 9'h104; core_mode = 2'b00;
    @(negedge clk);
    total++; if (core_rdata !== 32'hCAFEFACE) $display("FAIL mis_readback got %h exp cafeface", core_rdata); else pass++;
    next();
    core_addr = 9'h102;
    @(negedge clk);
    total++; if ({core_err, core_ack, mem_read} !== 3'b100) $display("FAIL mis_w_load got err/ack/rd %b %b %b exp 1 0 0", core_err, core_ack, mem_read); else pass++;
    next();
    idle();
  endtask

  task automatic test_range();
    reset_dut();
    dma_req = 1; dma_we = 1; dma_addr = 9'h0FC; dma_wdata = 32'h12345678;
    @(negedge clk);
    total++; if ({dma_err, dma_ack, mem_write} !== 3'b100) $display("FAIL range_low got err/ack/wr %b %b %b exp 1 0 0", dma_err, dma_ack, mem_write); else pass++;
    next();
    dma_addr = 9'h100; dma_wdata = 32'hA5A50001;
    @(negedge clk);
    total++; if ({dma_err, dma_ack, mem_write, mem_wdata} !== {3'b011, 32'hA5A50001}) $display("FAIL range_base got err/ack/wr/wd %b %b %b %h exp 0 1 1 a5a50001", dma_err, dma_ack, mem_write, mem_wdata); else pass++;
    next();
    dma_we = 0;
    @(negedge clk);
    total++; if (dma_rdata !== 32'hA5A50001) $display("FAIL range_readback got %h exp a5a50001", dma_rdata); else pass++;
    next();
    idle();
  endtask

  task automatic test_reset_mid_lock();
    reset_dut();
    core_req = 1; core_we = 1; core_addr = 9'h108; core_wdata = 32'h0BADF00D;
    next();
    idle();
    dma_req = 1; dma_lock = 1; dma_addr = 9'h108;
    next();
    dma_we = 1; dma_wdata = 32'hDEADBEEF;
    core_req = 1; core_addr = 9'h108;
    @(negedge clk);
    total++; if ({dma_ack, core_ack, mem_write} !== 3'b101) $display("FAIL midlock_pre got dma/core/wr %b %b %b exp 1 0 1", dma_ack, core_ack, mem_write); else pass++;
    #1 rst = 1;
    #1;
    total++; if ({mem_read, mem_write, mem_addr, mem_wdata, mem_mode, mem_sext} !== 46'h0) $display("FAIL midlock_mem got %h exp 0", {mem_read, mem_write, mem_addr, mem_wdata, mem_mode, mem_sext}); else pass++;
    total++; if ({dma_ack, dma_err, starve_cnt} !== 5'b0) $display("FAIL midlock_dma got ack/err/cnt %b %b %0d exp 0 0 0", dma_ack, dma_err, starve_cnt); else pass++;
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    total++; if ({core_ack, dma_ack} !== 2'b10) $display("FAIL midlock_after got core/dma %b %b exp 1 0", core_ack, dma_ack); else pass++;
    total++; if (core_rdata !== 32'h0BADF00D) $display("FAIL midlock_nowrite got %h exp 0badf00d", core_rdata); else pass++;
    next();
    idle();
  endtask

  task automatic test_random();
    bit c_hold, d_hold, dw, cw, ok, ref_lock;
    int ref_cnt, wa, wm;
    logic wwe, wsx;
    logic [31:0] wd, exp_rd;
    reset_dut();
    for (int i = 0; i < 512; i++) ref_mem[i] = env[i / 4][8*(i % 4) +: 8];
    c_hold = 0; d_hold = 0; ref_lock = 0; ref_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      if (!c_hold) begin
        core_req = $urandom_range(0, 2) != 0; core_we = 1'($urandom); core_wdata = $urandom;
        core_mode = 2'($urandom_range(0, 3)); core_sext = 1'($urandom);
        core_addr = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(256, 511));
        if ($urandom_range(0, 1) == 0) core_addr[1:0] = 2'b00;
      end
      if (!d_hold) begin
        dma_req = $urandom_range(0, 2) != 0; dma_we = 1'($urandom); dma_wdata = $urandom;
        dma_mode = 2'($urandom_range(0, 3)); dma_sext = 1'($urandom);
        dma_addr = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(256, 511));
        if ($urandom_range(0, 1) == 0) dma_addr[1:0] = 2'b00;
      end
      dma_lock = $urandom_range(0, 3) == 0;
      @(negedge clk);
      dw = dma_req && (ref_lock || ref_cnt == 4 || !core_req);
      cw = core_req && !dw;
      wa = dw ? int'(dma_addr) : int'(core_addr);
      wm = dw ? int'(dma_mode) : int'(core_mode);
      wwe = dw ? dma_we : core_we;
      wsx = dw ? dma_sext : core_sext;
      wd = dw ? dma_wdata : core_wdata;
      ok = (wm == 2 || (wm == 1 ? wa % 2 == 0 : wa % 4 == 0)) && wa / 4 >= 64;
      exp_rd = ref_load(wa, wm, wsx);
      total++; if ({core_ack, core_err} !== {cw && ok, cw && !ok}) $display("FAIL rnd_core_ack_err n=%0d got %b%b exp %b%b", n, core_ack, core_err, cw && ok, cw && !ok); else pass++;
      total++; if ({dma_ack, dma_err} !== {dw && ok, dw && !ok}) $display("FAIL rnd_dma_ack_err n=%0d got %b%b exp %b%b", n, dma_ack, dma_err, dw && ok, dw && !ok); else pass++;
      total++; if ({mem_read, mem_write} !== {(cw || dw) && ok && !wwe, (cw || dw) && ok && wwe}) $display("FAIL rnd_mem_rw n=%0d got %b%b exp %b%b", n, mem_read, mem_write, (cw || dw) && ok && !wwe, (cw || dw) && ok && wwe); else pass++;
      total++; if (starve_cnt !== 3'(ref_cnt)) $display("FAIL rnd_starve n=%0d got %0d exp %0d", n, starve_cnt, ref_cnt); else pass++;
      if (cw || dw) begin
        total++; if ({mem_addr, mem_mode, mem_sext} !== {9'(wa), 2'(wm), wsx}) $display("FAIL rnd_mem_bus n=%0d got %h %b %b exp %h %b %b", n, mem_addr, mem_mode, mem_sext, wa, 2'(wm), wsx); else pass++;
      end
      if (ok && wwe && (cw || dw)) begin
        total++; if (mem_wdata !== wd) $display("FAIL rnd_wdata n=%0d got %h exp %h", n, mem_wdata, wd); else pass++;
        ref_store(wa, wm, wd);
      end
      if (ok && !wwe && (cw || dw)) begin
        total++; if ((cw ? core_rdata : dma_rdata) !== exp_rd) $display("FAIL rnd_rdata n=%0d got %h exp %h", n, cw ? core_rdata : dma_rdata, exp_rd); else pass++;
      end
      total++; if ((cw ? dma_rdata : core_rdata) !== 32'h0) $display("FAIL rnd_loser_rdata n=%0d got %h exp 0", n, cw ? dma_rdata : core_rdata); else pass++;
      ref_cnt = (cw && dma_req) ? (ref_cnt < 4 ? ref_cnt + 1 : 4) : 0;
      ref_lock = dw && dma_lock;
      c_hold = core_req && !cw;
      d_hold = dma_req && !dw;
      next();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_core_alone();
    test_starvation();
    test_lock();
    test_misaligned();
    test_range();
    test_reset_mid_lock();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
